// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: 2-bit counter table with speculative global
// history, an in-flight FIFO that routes each update to its predicting entry.
module branch_predictor_gshare #(
  parameter int unsigned TABLE_BITS    = 7,
  parameter int unsigned GHR_BITS      = 6,
  parameter int unsigned MODE          = 1,
  parameter int unsigned BTFN_EN       = 1,
  parameter int unsigned PENDING_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_decode_sig,
  input  logic [31:0] in_addr,
  input  logic [31:0] offset,
  input  logic        branch_mem_sig,
  input  logic        actual_branch_decision,
  output logic [31:0] branch_addr,
  output logic        prediction,
  output logic        ready_o,
  output logic        mispredict_o,
  output logic        pending_full_o
);

  localparam int unsigned TABLE_SIZE = 1 << TABLE_BITS;
  localparam int unsigned PTR_BITS   = (PENDING_DEPTH > 1) ? $clog2(PENDING_DEPTH) : 1;
  localparam int unsigned CNT_BITS   = PTR_BITS + 1;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                  state_q;
  logic [TABLE_BITS-1:0] init_ptr_q;
  logic [1:0]            table_q [TABLE_SIZE];
  logic [GHR_BITS-1:0]   ghr_q;

  logic [TABLE_BITS-1:0] fifo_idx_q  [PENDING_DEPTH];
  logic                  fifo_pred_q [PENDING_DEPTH];
  logic [GHR_BITS-1:0]   fifo_ghr_q  [PENDING_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]   count_q, count_d;

  logic [TABLE_BITS-1:0] pc_idx, idx, head_idx;
  logic                  head_pred, static_taken, push, pop, mis;
  logic [GHR_BITS-1:0]   head_ghr, ghr_push, ghr_repair;
  logic [1:0]            head_ctr, head_ctr_next;
  logic                  unused_bits;

  assign ready_o      = (state_q == ST_RUN);
  assign branch_addr  = in_addr + offset;
  assign pc_idx       = in_addr[TABLE_BITS+1:2];
  assign idx          = (MODE != 0) ? (pc_idx ^ TABLE_BITS'(ghr_q)) : pc_idx;
  assign static_taken = (BTFN_EN != 0) & offset[31];

  assign prediction = ready_o & branch_decode_sig &
                      (pending_full_o ? static_taken : (table_q[idx][1] | static_taken));

  assign head_idx  = fifo_idx_q[rd_ptr_q];
  assign head_pred = fifo_pred_q[rd_ptr_q];
  assign head_ghr  = fifo_ghr_q[rd_ptr_q];

  assign pop  = ready_o & branch_mem_sig & (count_q != '0);
  assign mis  = pop & (actual_branch_decision != head_pred);
  assign push = ready_o & branch_decode_sig & ~pending_full_o & ~mis;

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_push   = prediction;
      assign ghr_repair = actual_branch_decision;
    end else begin : g_ghrn
      assign ghr_push   = {ghr_q[GHR_BITS-2:0], prediction};
      assign ghr_repair = {head_ghr[GHR_BITS-2:0], actual_branch_decision};
    end
  endgenerate

  assign unused_bits = ^{in_addr[31:TABLE_BITS+2], in_addr[1:0], head_ghr[GHR_BITS-1]};

  always_comb begin
    head_ctr      = table_q[head_idx];
    head_ctr_next = head_ctr;
    if (actual_branch_decision) begin
      if (head_ctr != 2'b11) head_ctr_next = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) head_ctr_next = head_ctr - 2'b01;
    end
  end

  always_comb begin
    count_d = count_q;
    if (mis)               count_d = '0;
    else if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_ptr_q <= init_ptr_q + 1'b1;
      if (init_ptr_q == '1) state_q <= ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q == ST_INIT) table_q[init_ptr_q] <= 2'b01;
      else if (pop)           table_q[head_idx]   <= head_ctr_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= idx;
      fifo_pred_q[wr_ptr_q] <= prediction;
      fifo_ghr_q[wr_ptr_q]  <= ghr_q;
    end
  end

  // A mispredict flushes wrong-path entries by snapping the read pointer onto
  // the write pointer; the same-cycle decode was already blocked via push.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ghr_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pending_full_o <= 1'b0;
      mispredict_o   <= 1'b0;
    end else begin
      count_q        <= count_d;
      pending_full_o <= (count_d == CNT_BITS'(PENDING_DEPTH));
      mispredict_o   <= mis;
      if (mis) begin
        ghr_q    <= ghr_repair;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) begin
          ghr_q    <= ghr_push;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a gshare/BTFN instance and a bimodal
// no-BTFN instance share stimulus and are compared against a behavioural model.
module tb_branch_predictor_gshare;

  localparam int unsigned PD = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, branch_decode_sig, branch_mem_sig, actual_branch_decision;
  logic [31:0] in_addr, offset;
  logic [31:0] baddr0, baddr1;
  logic [1:0]  pred_w, ready_w, mis_w, full_w;

  always #5 clk_i = ~clk_i;

  branch_predictor_gshare u_gs (
    .clk_i(clk_i), .rst_ni(rst_ni), .branch_decode_sig(branch_decode_sig),
    .in_addr(in_addr), .offset(offset), .branch_mem_sig(branch_mem_sig),
    .actual_branch_decision(actual_branch_decision), .branch_addr(baddr0),
    .prediction(pred_w[0]), .ready_o(ready_w[0]), .mispredict_o(mis_w[0]),
    .pending_full_o(full_w[0])
  );

  branch_predictor_gshare #(
    .TABLE_BITS(7), .GHR_BITS(6), .MODE(0), .BTFN_EN(0), .PENDING_DEPTH(2)
  ) u_bm (
    .clk_i(clk_i), .rst_ni(rst_ni), .branch_decode_sig(branch_decode_sig),
    .in_addr(in_addr), .offset(offset), .branch_mem_sig(branch_mem_sig),
    .actual_branch_decision(actual_branch_decision), .branch_addr(baddr1),
    .prediction(pred_w[1]), .ready_o(ready_w[1]), .mispredict_o(mis_w[1]),
    .pending_full_o(full_w[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model; instance 0 = gshare with BTFN, instance 1 = bimodal without.
  logic [1:0] m_tbl   [2][128];
  logic [5:0] m_ghr   [2];
  int         m_cnt   [2];
  logic [6:0] m_pidx  [2][PD];
  logic       m_ppred [2][PD];
  logic [5:0] m_pghr  [2][PD];
  int         init_left;
  logic [1:0] sb_q [$];

  function automatic logic [6:0] m_index(int i);
    logic [6:0] pc;
    pc = in_addr[8:2];
    if (i == 0) return pc ^ {1'b0, m_ghr[0]};
    return pc;
  endfunction

  function automatic logic m_pred(int i);
    logic       st;
    logic [1:0] c;
    st = (i == 0) && offset[31];
    if (init_left != 0 || !branch_decode_sig) return 1'b0;
    if (m_cnt[i] == PD) return st;
    c = m_tbl[i][m_index(i)];
    return c[1] | st;
  endfunction

  task automatic m_reset();
    init_left = 128;
    for (int i = 0; i < 2; i++) begin
      m_ghr[i] = '0;
      m_cnt[i] = 0;
      for (int e = 0; e < 128; e++) m_tbl[i][e] = 2'b01;
    end
  endtask

  task automatic m_edge(output logic [1:0] mis);
    logic       p, push_ok;
    logic [6:0] ix;
    logic [5:0] g;
    logic [1:0] c;
    mis = '0;
    if (!rst_ni) begin
      m_reset();
      return;
    end
    if (init_left != 0) begin
      init_left--;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      p       = m_pred(i);
      ix      = m_index(i);
      g       = m_ghr[i];
      push_ok = branch_decode_sig && (m_cnt[i] < PD);
      if (branch_mem_sig && m_cnt[i] > 0) begin
        c = m_tbl[i][m_pidx[i][0]];
        if (actual_branch_decision) begin
          if (c != 2'b11) c = c + 2'b01;
        end else if (c != 2'b00) c = c - 2'b01;
        m_tbl[i][m_pidx[i][0]] = c;
        if (actual_branch_decision != m_ppred[i][0]) begin
          mis[i]   = 1'b1;
          m_ghr[i] = {m_pghr[i][0][4:0], actual_branch_decision};
          m_cnt[i] = 0;
        end else begin
          for (int k = 0; k < PD - 1; k++) begin
            m_pidx[i][k]  = m_pidx[i][k+1];
            m_ppred[i][k] = m_ppred[i][k+1];
            m_pghr[i][k]  = m_pghr[i][k+1];
          end
          m_cnt[i]--;
        end
      end
      if (push_ok && !mis[i]) begin
        m_pidx[i][m_cnt[i]]  = ix;
        m_ppred[i][m_cnt[i]] = p;
        m_pghr[i][m_cnt[i]]  = g;
        m_cnt[i]++;
        m_ghr[i] = {g[4:0], p};
      end
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [31:0] pc,
                      input logic [31:0] off, input logic m, input logic a);
    logic [1:0] me, e;
    @(negedge clk_i);
    rst_ni = r; branch_decode_sig = d; in_addr = pc; offset = off;
    branch_mem_sig = m; actual_branch_decision = a;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("pred%0d", i), 32'(pred_w[i]), 32'(m_pred(i)));
      check_val($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(init_left == 0));
      check_val($sformatf("full%0d", i), 32'(full_w[i]), 32'(m_cnt[i] == PD));
    end
    check_val("baddr0", baddr0, pc + off);
    check_val("baddr1", baddr1, pc + off);
    m_edge(me);
    sb_q.push_back(me);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("mispredict", 32'(mis_w), 32'(e));
    end
  endtask

  task automatic reinit();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 128; k++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] pcs [4];
  logic [31:0] rpc, roff;

  initial begin
    pcs = '{32'h100, 32'h200, 32'h204, 32'h300};
    rst_ni = 1'b0; branch_decode_sig = 1'b0; branch_mem_sig = 1'b0;
    actual_branch_decision = 1'b0; in_addr = '0; offset = '0;
    repeat (2) @(posedge clk_i);
    m_reset();

    // INIT with noisy decode/resolve, restarted by a reset pulse at cycle 50
    for (int k = 0; k < 50; k++) step(1'b1, 1'b1, 32'h100, 32'h20, k[0], 1'b1);
    step(1'b0, 1'b0, 32'h100, 32'h20, 1'b0, 1'b0);
    for (int k = 0; k < 130; k++) step(1'b1, (k % 3) == 0, 32'h100, 32'h20, (k % 5) == 0, 1'b1);
    check_val("ready_after_init", 32'(ready_w), 32'h3);

    // Every entry starts weakly not-taken: one taken resolve then predicts taken (bimodal)
    for (int k = 0; k < 128; k++) begin
      step(1'b1, 1'b1, 32'(k) << 2, 32'h20, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    end
    for (int k = 0; k < 128; k++) begin
      step(1'b1, 1'b1, 32'(k) << 2, 32'h20, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    end

    // Counter training and BTFN from a fresh table
    reinit();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 32'h100, 32'h20, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h100, 32'h20, 1'b1, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 32'h100, 32'h20, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h100, 32'h20, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 32'h100, 32'hFFFF_FFF0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 32'h200, 32'h20, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, k < 4);
    end

    // FIFO fill, full-decode, pop+push, mispredict with concurrent decode, empty resolve
    step(1'b1, 1'b1, 32'h300, 32'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h304, 32'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h308, 32'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h30C, 32'h20, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h310, 32'h20, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomised traffic with one mid-run reset
    for (int k = 0; k < 3000; k++) begin
      rpc  = (($urandom % 4) == 0) ? $urandom : pcs[$urandom % 4];
      roff = (($urandom % 2) == 0) ? ($urandom % 1024) : (32'hFFFF_FF00 | ($urandom % 256));
      step(k != 1500, ($urandom % 3) != 0, rpc, roff, ($urandom % 2) == 0, ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the single-counter branch predictor. It holds a table of 2-bit saturating counters indexed by PC, or by PC XOR global history. It keeps a speculative global history register (GHR) and repairs it on mispredict, and tracks in-flight branches in a small FIFO so each counter update goes to the entry that made the prediction. Sits between ID (prediction, target) and MEM (resolution) of the RV32I pipeline.

Parameters:
TABLE_BITS, 7, log2 of counter-table entries (TABLE_SIZE = 2^TABLE_BITS)
GHR_BITS, 6, global history length; 1 <= GHR_BITS <= TABLE_BITS
MODE, 1, 0 = bimodal (PC index only), 1 = gshare (PC index XOR GHR)
BTFN_EN, 1, 1 = backward branches (offset[31]=1) are always predicted taken
PENDING_DEPTH, 2, in-flight FIFO depth; power of two, >= 2

Ports:
clk_i  in  1  single clock; all state updates on posedge
rst_ni  in  1  synchronous active-low reset (already decided)
branch_decode_sig  in  1  ID stage holds a conditional branch this cycle
in_addr  in  32  PC of the branch in ID
offset  in  32  sign-extended branch immediate
branch_mem_sig  in  1  one-cycle pulse: oldest in-flight branch resolves in MEM
actual_branch_decision  in  1  resolved outcome, valid with branch_mem_sig
branch_addr  out  32  in_addr + offset, modulo 2^32, combinational
prediction  out  1  1 = predict taken, combinational
ready_o  out  1  table initialised, predictor active
mispredict_o  out  1  registered one-cycle pulse after a mispredicted resolve
pending_full_o  out  1  in-flight FIFO full

Behaviour:
- Reset: rst_ni sampled low at posedge enters INIT. Clears init_ptr=0, GHR=0 and FIFO count/pointers. Drives ready_o=0, mispredict_o=0 and pending_full_o=0.
- Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0.
- FSM INIT: writes one entry per cycle to 2'b01 (weakly not-taken), init_ptr increments. After writing entry TABLE_SIZE-1, moves to RUN; ready_o=1 from the next cycle. Init takes exactly TABLE_SIZE cycles after rst_ni rises.
- In INIT, prediction=0, and decode and resolve inputs are ignored.
- Index: pc_idx = in_addr[TABLE_BITS+1:2].
  - MODE=0: idx = pc_idx.
  - MODE=1: idx = pc_idx XOR zero-extended GHR.
- prediction = ready_o & branch_decode_sig & (table[idx][1] | (BTFN_EN & offset[31])).
- No read-after-write bypass: a same-cycle update to the same index is not visible until the next cycle.
- Decode push, at posedge with ready_o & branch_decode_sig & !full:
  - Pushes {idx, prediction, GHR snapshot}.
  - Updates GHR <= {GHR[GHR_BITS-2:0], prediction}; for GHR_BITS=1, GHR <= prediction.
- Decode while full: no push, no GHR change. prediction is forced to the static BTFN value, BTFN_EN & offset[31]. The branch later resolves with no counter update and no repair; the bench must never resolve more branches than were pushed.
- Resolve, at posedge with ready_o & branch_mem_sig & FIFO non-empty:
  - Pops the head entry.
  - Updates table[head.idx] as a saturating counter: +1 if actual=1, -1 if actual=0, saturating at 00 and 11.
- Resolve with actual != head.pred:
  - GHR <= {head.ghr[GHR_BITS-2:0], actual}.
  - Flushes all remaining FIFO entries (wrong path); count=0.
  - mispredict_o=1 on the next cycle only.
- Resolve with empty FIFO: ignored; no table, GHR or mispredict change.
- Simultaneous decode and resolve:
  - Correct prediction: pop and push both occur; count unchanged; GHR takes the speculative shift.
  - Mispredict: repair wins; the same-cycle decode is discarded (no push, no shift).
- pending_full_o = (count == PENDING_DEPTH), registered with the count.
- FIFO pointers wrap modulo PENDING_DEPTH.
- All counter and GHR arithmetic is unsigned at its declared width; no X propagates after INIT.

Test Plan:
- Hold rst_ni=0 2 cycles, release -> ready_o=0 for exactly 128 cycles (TABLE_BITS=7), then 1; every entry reads 01; prediction=0 for a forward branch; pulse rst_ni low at init cycle 50 -> INIT restarts, ready_o rises 128 cycles after the second release.
- MODE=0, PC 0x100, offset +0x20: three resolves taken -> prediction becomes 1 after the first resolve (01->10), counter saturates at 11; then three not-taken -> 10, 01, 00, prediction 0 after the second. branch_addr=0x120.
- BTFN: offset 0xFFFFFFF0 with counter 00 -> prediction=1. Same case with BTFN_EN=0 -> prediction=0.
- MODE=1: PC 0x200 trained taken with GHR=000000 and not-taken with GHR=000011 -> the two contexts use distinct entries (idx 0x00 vs 0x03) and predict 1 and 0 respectively.
- Two decodes predicted taken (GHR 0 -> 1 -> 3), first resolves not-taken -> mispredict_o pulses 1 cycle later, GHR=000000 (snapshot 0 shifted with 0), FIFO count=0, second branch's resolve ignored; concurrent decode in the resolve cycle is not pushed.
- Fill FIFO (2 decodes, no resolve) -> pending_full_o=1; third decode with a forward offset gives prediction=0 and no GHR change; one correct resolve plus a decode in the same cycle -> count stays 2.
